// File: rtl/pc_fetch_sequencer.sv
// Program-counter register and fetch sequencer wrapped around an external 5-bit incrementer.
// Presents PC to instruction memory with a valid/ready handshake; supports redirect, stall and halt.
module pc_fetch_sequencer #(
    parameter logic [4:0] RESET_PC  = 5'd0,
    parameter int         CNT_WIDTH = 8
) (
    input  logic                 Clock,
    input  logic                 Reset_n,
    input  logic [4:0]           IncIn,
    input  logic                 Stall,
    input  logic                 Load,
    input  logic [4:0]           LoadAddr,
    input  logic                 Halt,
    input  logic                 FetchReady,
    output logic [4:0]           PC,
    output logic                 FetchValid,
    output logic                 Wrapped,
    output logic                 Halted,
    output logic [CNT_WIDTH-1:0] FetchCount
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FETCH  = 2'd1,
        HALTED = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [4:0]             pc_q, pc_d;
    logic [CNT_WIDTH-1:0]   count_q, count_d;
    logic                   wrapped_q, wrapped_d;
    logic                   accept;

    // FetchValid is a pure decode of the registered state, so it drops with reset asynchronously.
    assign FetchValid = (state_q == FETCH);
    assign Halted     = (state_q == HALTED);
    assign PC         = pc_q;
    assign Wrapped    = wrapped_q;
    assign FetchCount = count_q;

    assign accept = FetchValid & FetchReady & ~Stall;

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        count_d   = count_q;
        wrapped_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                state_d = FETCH;
            end
            FETCH: begin
                if (!Stall) begin
                    // A redirect takes effect whether or not the current fetch was accepted.
                    if (Load) begin
                        pc_d = LoadAddr;
                    end else if (accept) begin
                        pc_d      = IncIn;
                        wrapped_d = (pc_q == 5'd31);
                    end
                    if (accept) begin
                        count_d = count_q + CNT_WIDTH'(1);
                    end
                    if (Halt) begin
                        state_d = HALTED;
                    end
                end
            end
            HALTED: begin
                state_d = HALTED;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q   <= IDLE;
            pc_q      <= RESET_PC;
            count_q   <= '0;
            wrapped_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            count_q   <= count_d;
            wrapped_q <= wrapped_d;
        end
    end

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// Directed bench for pc_fetch_sequencer with a behavioural incrementer closing the PC loop.
module tb_pc_fetch_sequencer;

    logic       Clock;
    logic       Reset_n;
    logic [4:0] IncIn;
    logic       Stall;
    logic       Load;
    logic [4:0] LoadAddr;
    logic       Halt;
    logic       FetchReady;
    logic [4:0] PC;
    logic       FetchValid;
    logic       Wrapped;
    logic       Halted;
    logic [7:0] FetchCount;

    int n_cmp;
    int n_err;

    pc_fetch_sequencer #(
        .RESET_PC  (5'd0),
        .CNT_WIDTH (8)
    ) dut (
        .Clock      (Clock),
        .Reset_n    (Reset_n),
        .IncIn      (IncIn),
        .Stall      (Stall),
        .Load       (Load),
        .LoadAddr   (LoadAddr),
        .Halt       (Halt),
        .FetchReady (FetchReady),
        .PC         (PC),
        .FetchValid (FetchValid),
        .Wrapped    (Wrapped),
        .Halted     (Halted),
        .FetchCount (FetchCount)
    );

    // The incrementer stage the sequencer sits around: PC+1 mod 32.
    assign IncIn = PC + 5'd1;

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_state(input string tag, input int pc, input int fv,
                             input int wr, input int hl, input int cnt);
        check_eq({tag, ".pc"},    int'(PC),         pc);
        check_eq({tag, ".fv"},    int'(FetchValid), fv);
        check_eq({tag, ".wrap"},  int'(Wrapped),    wr);
        check_eq({tag, ".halt"},  int'(Halted),     hl);
        check_eq({tag, ".count"}, int'(FetchCount), cnt);
    endtask

    task automatic drive(input logic st, input logic ld, input logic [4:0] la,
                         input logic ht, input logic fr);
        Stall = st; Load = ld; LoadAddr = la; Halt = ht; FetchReady = fr;
    endtask

    // Drive the inputs for the next rising edge, then sample at the following falling edge.
    task automatic step(input logic st, input logic ld, input logic [4:0] la,
                        input logic ht, input logic fr);
        drive(st, ld, la, ht, fr);
        @(negedge Clock);
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        Reset_n = 1'b0;
        drive(1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
        #2;
        chk_state("reset", 0, 0, 0, 0, 0);

        // Release in the low phase; Load/Halt asserted during IDLE must be ignored.
        @(negedge Clock);
        Reset_n = 1'b1;
        drive(1'b0, 1'b1, 5'd20, 1'b1, 1'b1);
        #1;
        chk_state("idle", 0, 0, 0, 0, 0);
        @(negedge Clock);
        chk_state("fetch0", 0, 1, 0, 0, 0);

        step(1'b0, 1'b0, 5'd0, 1'b0, 1'b1);
        chk_state("seq1", 1, 1, 0, 0, 1);
        step(1'b0, 1'b0, 5'd0, 1'b0, 1'b1);
        chk_state("seq2", 2, 1, 0, 0, 2);
        step(1'b0, 1'b0, 5'd0, 1'b0, 1'b1);
        chk_state("seq3", 3, 1, 0, 0, 3);

        // Redirect to 23 without accept, then hold for three not-ready cycles.
        step(1'b0, 1'b1, 5'd23, 1'b0, 1'b0);
        chk_state("redir23", 23, 1, 0, 0, 3);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
            chk_state("hold23", 23, 1, 0, 0, 3);
        end
        step(1'b0, 1'b0, 5'd0, 1'b0, 1'b1);
        chk_state("acc23", 24, 1, 0, 0, 4);

        // Wrap from 31 to 0, then a load to 0 must not pulse Wrapped.
        step(1'b0, 1'b1, 5'd31, 1'b0, 1'b0);
        chk_state("redir31", 31, 1, 0, 0, 4);
        step(1'b0, 1'b0, 5'd0, 1'b0, 1'b1);
        chk_state("wrap", 0, 1, 1, 0, 5);
        step(1'b0, 1'b1, 5'd0, 1'b0, 1'b0);
        chk_state("load0", 0, 1, 0, 0, 5);
        step(1'b0, 1'b1, 5'd31, 1'b0, 1'b0);
        step(1'b0, 1'b1, 5'd0, 1'b0, 1'b1);
        chk_state("accload0", 0, 1, 0, 0, 6);

        // Load at PC=5: redirect, accepted load, stalled load.
        step(1'b0, 1'b1, 5'd5, 1'b0, 1'b0);
        chk_state("pc5a", 5, 1, 0, 0, 6);
        step(1'b0, 1'b1, 5'd17, 1'b0, 1'b0);
        chk_state("redir17", 17, 1, 0, 0, 6);
        step(1'b0, 1'b1, 5'd5, 1'b0, 1'b0);
        step(1'b0, 1'b1, 5'd17, 1'b0, 1'b1);
        chk_state("accld17", 17, 1, 0, 0, 7);
        step(1'b0, 1'b1, 5'd5, 1'b0, 1'b0);
        chk_state("pc5b", 5, 1, 0, 0, 7);
        step(1'b1, 1'b1, 5'd17, 1'b0, 1'b1);
        chk_state("stallld", 5, 1, 0, 0, 7);
        step(1'b1, 1'b0, 5'd0, 1'b1, 1'b1);
        chk_state("stallhalt", 5, 1, 0, 0, 7);

        // Halt together with an accept at PC=8: fetch completes, then the block halts.
        step(1'b0, 1'b1, 5'd8, 1'b0, 1'b0);
        chk_state("pc8", 8, 1, 0, 0, 7);
        step(1'b0, 1'b0, 5'd0, 1'b1, 1'b1);
        chk_state("halt", 9, 0, 0, 1, 8);
        step(1'b0, 1'b1, 5'd3, 1'b0, 1'b1);
        chk_state("halted1", 9, 0, 0, 1, 8);
        step(1'b0, 1'b0, 5'd3, 1'b0, 1'b0);
        chk_state("halted2", 9, 0, 0, 1, 8);

        // Restart, reach PC=12 with a nonzero count, then reset mid-cycle.
        Reset_n = 1'b0;
        #1;
        chk_state("rst2", 0, 0, 0, 0, 0);
        @(negedge Clock);
        Reset_n = 1'b1;
        step(1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
        chk_state("refetch", 0, 1, 0, 0, 0);
        step(1'b0, 1'b0, 5'd0, 1'b0, 1'b1);
        chk_state("reacc", 1, 1, 0, 0, 1);
        step(1'b0, 1'b1, 5'd12, 1'b0, 1'b0);
        chk_state("pc12", 12, 1, 0, 0, 1);
        drive(1'b0, 1'b0, 5'd0, 1'b0, 1'b1);
        @(posedge Clock);
        #2;
        chk_state("pc13", 13, 1, 0, 0, 2);
        Reset_n = 1'b0;
        #1;
        chk_state("midrst", 0, 0, 0, 0, 0);
        @(negedge Clock);
        chk_state("inrst", 0, 0, 0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
